// File: rtl/fb_pkg.sv
// Frame-buffer defaults and arbiter state encoding, shared by the arbiter
// and the display readout side.
package fb_pkg;

  localparam int DEF_ADDR_W   = 12;
  localparam int DEF_DATA_W   = 24;
  localparam int DEF_FB_DEPTH = 2305;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/fb_port_arbiter.sv
// Two-requester (CPU / image loader) arbiter for frame-buffer RAM port A.
// Optional per-requester beat counters: define FB_ARB_STATS_EN.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FB_DEPTH  = DEF_FB_DEPTH,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_we,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        req_ready,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
`ifdef FB_ARB_STATS_EN
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1,
`endif
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [7:0]      BURST_LIM = 8'(MAX_BURST);
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(FB_DEPTH);

  arb_state_e  state, state_nxt;
  logic        last_grant, last_grant_nxt;
  logic [7:0]  burst_cnt, burst_cnt_nxt, cnt_inc;

  logic [1:0]        beat_vec_p0;
  logic              beat_p0;
  logic              beat_we_p0;
  logic [ADDR_W-1:0] beat_addr_p0;
  logic              in_range_p0;
  logic [1:0]        vld_p1;
  logic              oob_p1;

  // Stage p0: grant decode and combinational RAM drive for the accepted beat
  assign req_ready[0] = (state == ST_OWN0) && req_valid[0];
  assign req_ready[1] = (state == ST_OWN1) && req_valid[1];

  assign beat_vec_p0  = req_valid & req_ready;
  assign beat_p0      = |beat_vec_p0;
  assign beat_we_p0   = (state == ST_OWN1) ? req_we[1]  : req_we[0];
  assign beat_addr_p0 = (state == ST_OWN1) ? req_addr1  : req_addr0;
  assign in_range_p0  = {1'b0, beat_addr_p0} < DEPTH_LIM;

  assign ram_addr  = beat_addr_p0;
  assign ram_wdata = (state == ST_OWN1) ? req_wdata1 : req_wdata0;
  assign ram_we    = beat_p0 &&  beat_we_p0 && in_range_p0;
  assign ram_re    = beat_p0 && !beat_we_p0 && in_range_p0;

  assign cnt_inc = (burst_cnt >= BURST_LIM) ? BURST_LIM : burst_cnt + 8'd1;

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    burst_cnt_nxt  = burst_cnt;
    case (state)
      ST_IDLE: begin
        if (req_valid == 2'b11)
          state_nxt = last_grant ? ST_OWN0 : ST_OWN1;
        else if (req_valid[0])
          state_nxt = ST_OWN0;
        else if (req_valid[1])
          state_nxt = ST_OWN1;
      end
      ST_OWN0: begin
        if (!req_valid[0]) begin
          state_nxt = req_valid[1] ? ST_OWN1 : ST_IDLE;
        end else begin
          burst_cnt_nxt = cnt_inc;
          if (cnt_inc == BURST_LIM && req_valid[1])
            state_nxt = ST_OWN1;
        end
      end
      ST_OWN1: begin
        if (!req_valid[1]) begin
          state_nxt = req_valid[0] ? ST_OWN0 : ST_IDLE;
        end else begin
          burst_cnt_nxt = cnt_inc;
          if (cnt_inc == BURST_LIM && req_valid[0])
            state_nxt = ST_OWN0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Limit is evaluated including the current beat, so the handover lands
    // right after the MAX_BURST-th beat without gating ready on the counter.
    if (state_nxt != state)
      burst_cnt_nxt = 8'd0;
    if (state_nxt == ST_OWN0 && state != ST_OWN0)
      last_grant_nxt = 1'b0;
    if (state_nxt == ST_OWN1 && state != ST_OWN1)
      last_grant_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      burst_cnt  <= 8'd0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

  // Stage p1: read response one cycle after the read beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 2'b00;
      oob_p1 <= 1'b0;
    end else begin
      vld_p1 <= (beat_p0 && !beat_we_p0) ? beat_vec_p0 : 2'b00;
      oob_p1 <= !in_range_p0;
    end
  end

  assign rsp_valid = vld_p1;
  assign rsp_rdata = (|vld_p1 && !oob_p1) ? ram_rdata : '0;

`ifdef FB_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= 16'd0;
      grant_cnt1 <= 16'd0;
    end else begin
      if (beat_vec_p0[0] && grant_cnt0 != 16'hFFFF)
        grant_cnt0 <= grant_cnt0 + 16'd1;
      if (beat_vec_p0[1] && grant_cnt1 != 16'hFFFF)
        grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed self-checking bench for fb_port_arbiter with a behavioural RAM on port A.
module tb_fb_port_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 24;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_we;
  logic [ADDR_W-1:0] req_addr0, req_addr1;
  logic [DATA_W-1:0] req_wdata0, req_wdata1;
  logic [1:0]        req_ready;
  logic [1:0]        rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
`ifdef FB_ARB_STATS_EN
  logic [15:0]       grant_cnt0, grant_cnt1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fb_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_DEPTH(2305), .MAX_BURST(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
`ifdef FB_ARB_STATS_EN
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
    .ram_rdata(ram_rdata)
  );

  // Port-A RAM: synchronous read, output holds when not reading
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc, other, seq_err, both_err, n0, n1;
    logic [1:0] exp_rdy;
    rst_n = 1'b0; req_valid = 2'b00; req_we = 2'b00;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 2'b11; #2;
    check_val("rst_ready", 32'(req_ready), 32'd0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check_val("rst_ram_en", 32'({ram_we, ram_re}), 32'd0);

    // Requester 0 writes 0xFF0000 to addr 5, then reads it back
    step; rst_n = 1'b1; req_valid = 2'b01; req_we = 2'b01;
    req_addr0 = 12'd5; req_wdata0 = 24'hFF0000; #2;
    check_val("grant_registered", 32'(req_ready), 32'd0);
    step; #2;
    check_val("wr_ready", 32'(req_ready), 32'h1);
    check_val("wr_ram_we", 32'({ram_we, ram_re}), 32'h2);
    check_val("wr_ram_addr", 32'(ram_addr), 32'd5);
    check_val("wr_ram_wdata", 32'(ram_wdata), 32'hFF0000);
    step; req_we = 2'b00; #2;
    check_val("rd_ram_re", 32'({ram_we, ram_re}), 32'h1);
    check_val("wr_no_rsp", 32'(rsp_valid), 32'd0);
    step; req_valid = 2'b00; #2;
    check_val("rd_rsp_valid", 32'(rsp_valid), 32'h1);
    check_val("rd_rsp_rdata", 32'(rsp_rdata), 32'hFF0000);
    step; #2;
    check_val("rsp_pulse_end", 32'(rsp_valid), 32'd0);
    check_val("rdata_zero_idle", 32'(rsp_rdata), 32'd0);

    // Requester 1 reads out-of-range addresses 2305 and 4095
    step; req_valid = 2'b10; req_we = 2'b00; req_addr1 = 12'd2305; #2;
    check_val("oob_grant_wait", 32'(req_ready), 32'd0);
    step; #2;
    check_val("oob_ready", 32'(req_ready), 32'h2);
    check_val("oob2305_no_ram", 32'({ram_we, ram_re}), 32'd0);
    step; req_addr1 = 12'd4095; #2;
    check_val("oob4095_no_ram", 32'({ram_we, ram_re}), 32'd0);
    check_val("oob2305_rsp_valid", 32'(rsp_valid), 32'h2);
    check_val("oob2305_rdata", 32'(rsp_rdata), 32'd0);
    step; req_valid = 2'b00; #2;
    check_val("oob4095_rsp_valid", 32'(rsp_valid), 32'h2);
    check_val("oob4095_rdata", 32'(rsp_rdata), 32'd0);

    // Requester 0 alone streams 20 writes: no release at the burst limit
    step; req_valid = 2'b01; req_we = 2'b01; #2;
    acc = 0; other = 0;
    for (int i = 0; i < 20; i++) begin
      step; req_addr0 = 12'(100 + i); req_wdata0 = 24'(i); #2;
      if (req_ready[0]) acc++;
      if (req_ready[1]) other++;
    end
    check_val("stream20_accepts", 32'(acc), 32'd20);
    check_val("stream20_no_other", 32'(other), 32'd0);
    // Saturated counter: a newcomer takes over right after the next beat
    step; req_valid = 2'b11; req_we = 2'b11; #2;
    check_val("sat_extra_beat", 32'(req_ready), 32'h1);
    step; #2;
    check_val("sat_handover", 32'(req_ready), 32'h2);

    // Reset asserted the cycle after a read beat
    step; req_valid = 2'b00;
    step; req_valid = 2'b01; req_we = 2'b00; req_addr0 = 12'd5;
    step; #2;
    check_val("pre_rst_read", 32'({ram_we, ram_re}), 32'h1);
    step; rst_n = 1'b0; req_valid = 2'b00; #2;
    check_val("rst_drop_rsp", 32'(rsp_valid), 32'd0);
    step; step; rst_n = 1'b1; #2;
    check_val("post_rst_rsp", 32'(rsp_valid), 32'd0);

    // Both requesting from IDLE: 8-beat alternation, requester 0 first
    req_valid = 2'b11; req_we = 2'b11; req_addr0 = 12'd10; req_addr1 = 12'd20; #1;
    seq_err = 0; both_err = 0; n0 = 0; n1 = 0;
    for (int c = 0; c < 32; c++) begin
      if (c == 0) exp_rdy = 2'b00;
      else if (((c - 1) / 8) % 2 == 0) exp_rdy = 2'b01;
      else exp_rdy = 2'b10;
      if (req_ready !== exp_rdy) seq_err++;
      if (req_ready == 2'b11) both_err++;
      if (req_ready[0]) n0++;
      if (req_ready[1]) n1++;
      step; #2;
    end
    check_val("alt_sequence_errs", 32'(seq_err), 32'd0);
    check_val("alt_both_ready", 32'(both_err), 32'd0);
    check_val("alt_beats0", 32'(n0), 32'd16);
    check_val("alt_beats1", 32'(n1), 32'd15);
`ifdef FB_ARB_STATS_EN
    check_val("stats_cnt0", 32'(grant_cnt0), 32'd16);
    check_val("stats_cnt1", 32'(grant_cnt1), 32'd15);
`endif

    req_valid = 2'b00;
    step;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
